syncfifo_showahead_sclr_param: RTL

// - Parametrised single-clock show-ahead FIFO. Successor to the fixed 71x32 aclr FIFOs in the time-sensitive switch.
// - Used for descriptor/metadata queues between switch stages.
// - Adds: generic width/depth, full-range usedw, programmable almost-full/empty, sticky overflow/underflow flags, full+read write-through.

---
 rtl/syncfifo_pkg.sv | 35 +++
 rtl/syncfifo_sdpram.sv | 29 ++
 rtl/syncfifo_showahead_sclr_param.sv | 110 +++++++++++
 3 files changed

// File: rtl/syncfifo_pkg.sv
// Shared types and helpers for the parametrised show-ahead FIFO.
// Occupancy is carried as one struct so every flag comes from the same count.
package syncfifo_pkg;

    localparam int MIN_DEPTH = 4;
    localparam int OCC_W     = 32;

    typedef struct packed {
        logic [OCC_W-1:0] usedw;
        logic             full;
        logic             empty;
        logic             almost_full;
        logic             almost_empty;
    } occ_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // All flags derive from one occupancy value so they never disagree with usedw.
    function automatic occ_t occ_eval(input logic [OCC_W-1:0] u, input int depth,
                                      input int af_lvl, input int ae_lvl);
        occ_t o;
        o.usedw        = u;
        o.full         = (u == OCC_W'(depth));
        o.empty        = (u == '0);
        o.almost_full  = (u >= OCC_W'(af_lvl));
        o.almost_empty = (u <= OCC_W'(ae_lvl));
        return o;
    endfunction

endpackage

// File: rtl/syncfifo_sdpram.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// The asynchronous read port is what gives the FIFO its zero-latency show-ahead head word.
module syncfifo_sdpram
    import syncfifo_pkg::*;
#(
    parameter int DW    = 71,
    parameter int DEPTH = 32,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Contents are intentionally never reset; the FIFO tracks validity through occupancy.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/syncfifo_showahead_sclr_param.sv
// Single-clock show-ahead FIFO with synchronous clear, sticky error flags and full+read write-through.
// Optional storage parity is enabled by defining SYNCFIFO_PARITY_EN (adds the parity_err output).
module syncfifo_showahead_sclr_param
    import syncfifo_pkg::*;
#(
    parameter int DW     = 71,
    parameter int DEPTH  = 32,
    parameter int AF_LVL = 28,
    parameter int AE_LVL = 2,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          sclr,
    input  logic [DW-1:0] data,
    input  logic          wrreq,
    input  logic          rdreq,
    input  logic          err_clr,
    output logic [DW-1:0] q,
    output logic [AW:0]   usedw,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
`ifdef SYNCFIFO_PARITY_EN
    output logic          underflow,
    output logic          parity_err
`else
    output logic          underflow
`endif
);

`ifdef SYNCFIFO_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif

    occ_t          occ_q;
    occ_t          occ_n;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          overflow_q;
    logic          underflow_q;
    logic          rd_acc;
    logic          wr_acc;
    logic [MW-1:0] wr_word;
    logic [MW-1:0] rd_word;
    logic          unused_usedw_hi;

    // A read at full frees the slot, so the write is still taken that cycle.
    assign rd_acc = rdreq & ~occ_q.empty;
    assign wr_acc = wrreq & (~occ_q.full | rdreq);

    always_comb begin
        occ_n = occ_eval(occ_q.usedw + OCC_W'(wr_acc) - OCC_W'(rd_acc), DEPTH, AF_LVL, AE_LVL);
    end

`ifdef SYNCFIFO_PARITY_EN
    assign wr_word    = {^data, data};
    assign parity_err = (^rd_word) & ~occ_q.empty;
`else
    assign wr_word    = data;
`endif

    syncfifo_sdpram #(
        .DW    (MW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_acc & ~sclr),
        .wr_addr (wr_ptr),
        .wr_data (wr_word),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    // Clear wins over everything; err_clr wins over a same-cycle error set.
    always_ff @(posedge clock) begin
        if (sclr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ_q       <= occ_eval('0, DEPTH, AF_LVL, AE_LVL);
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            occ_q <= occ_n;
            if (err_clr) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end else begin
                if (wrreq & occ_q.full & ~rdreq) overflow_q  <= 1'b1;
                if (rdreq & occ_q.empty)         underflow_q <= 1'b1;
            end
        end
    end

    assign q               = rd_word[DW-1:0];
    assign usedw           = occ_q.usedw[AW:0];
    assign unused_usedw_hi = ^occ_q.usedw[OCC_W-1:AW+1];
    assign full            = occ_q.full;
    assign empty           = occ_q.empty;
    assign almost_full     = occ_q.almost_full;
    assign almost_empty    = occ_q.almost_empty;
    assign overflow        = overflow_q;
    assign underflow       = underflow_q;

endmodule
